// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 set-2 scan codes and ASCII constants
package ps2_pkg;

    localparam logic [7:0] BREAK_CODE    = 8'hF0;
    localparam logic [7:0] EXTENDED_CODE = 8'hE0;

    localparam logic [7:0] SC_A = 8'h1C;
    localparam logic [7:0] SC_B = 8'h32;
    localparam logic [7:0] SC_C = 8'h21;
    localparam logic [7:0] SC_D = 8'h23;
    localparam logic [7:0] SC_E = 8'h24;
    localparam logic [7:0] SC_F = 8'h2B;
    localparam logic [7:0] SC_G = 8'h34;
    localparam logic [7:0] SC_H = 8'h33;
    localparam logic [7:0] SC_I = 8'h43;
    localparam logic [7:0] SC_J = 8'h3B;
    localparam logic [7:0] SC_K = 8'h42;
    localparam logic [7:0] SC_L = 8'h4B;
    localparam logic [7:0] SC_M = 8'h3A;
    localparam logic [7:0] SC_N = 8'h31;
    localparam logic [7:0] SC_O = 8'h44;
    localparam logic [7:0] SC_P = 8'h4D;
    localparam logic [7:0] SC_Q = 8'h15;
    localparam logic [7:0] SC_R = 8'h2D;
    localparam logic [7:0] SC_S = 8'h1B;
    localparam logic [7:0] SC_T = 8'h2C;
    localparam logic [7:0] SC_U = 8'h3C;
    localparam logic [7:0] SC_V = 8'h2A;
    localparam logic [7:0] SC_W = 8'h1D;
    localparam logic [7:0] SC_X = 8'h22;
    localparam logic [7:0] SC_Y = 8'h35;
    localparam logic [7:0] SC_Z = 8'h1A;

    localparam logic [7:0] SC_0 = 8'h45;
    localparam logic [7:0] SC_1 = 8'h16;
    localparam logic [7:0] SC_2 = 8'h1E;
    localparam logic [7:0] SC_3 = 8'h26;
    localparam logic [7:0] SC_4 = 8'h25;
    localparam logic [7:0] SC_5 = 8'h2E;
    localparam logic [7:0] SC_6 = 8'h36;
    localparam logic [7:0] SC_7 = 8'h3D;
    localparam logic [7:0] SC_8 = 8'h3E;
    localparam logic [7:0] SC_9 = 8'h46;

    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_BKSP  = 8'h66;
    localparam logic [7:0] SC_ESC   = 8'h76;

    localparam logic [7:0] ASCII_NUL = 8'h00;
    localparam logic [7:0] ASCII_BS  = 8'h08;
    localparam logic [7:0] ASCII_CR  = 8'h0D;
    localparam logic [7:0] ASCII_ESC = 8'h1B;
    localparam logic [7:0] ASCII_SP  = 8'h20;

endpackage

// File: rtl/ps2_delay_timer.sv
// rtl/ps2_delay_timer.sv - one-shot delay timer armed by a rising start level
module ps2_delay_timer
    import ps2_pkg::*;
#(
    parameter int unsigned DELAY_CYCLES = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    output logic finish
);

    localparam int CNT_W = $clog2(DELAY_CYCLES + 1);
    localparam logic [CNT_W-1:0] LOAD_VALUE = CNT_W'(DELAY_CYCLES - 1);

    logic             start_d;
    logic             running;
    logic [CNT_W-1:0] count;
    logic             trigger;

    // Only a fresh rise of start arms the timer; a held level re-arms nothing.
    assign trigger = start & ~start_d;

    // Count down once armed; triggers arriving while running are dropped.
    always_ff @(posedge clock) begin
        if (reset) begin
            start_d <= 1'b0;
            running <= 1'b0;
            count   <= '0;
            finish  <= 1'b0;
        end else begin
            start_d <= start;
            finish  <= 1'b0;
            if (running) begin
                if (count != '0) begin
                    count <= count - CNT_W'(1);
                end else begin
                    running <= 1'b0;
                    finish  <= 1'b1;
                end
            end else if (trigger) begin
                running <= 1'b1;
                count   <= LOAD_VALUE;
            end
        end
    end

endmodule

// File: rtl/ps2_keypress_decoder.sv
// rtl/ps2_keypress_decoder.sv - break-qualified keypress strobe plus scan-code to ASCII map
module ps2_keypress_decoder
    import ps2_pkg::*;
#(
    parameter int unsigned DELAY_CYCLES = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] ps2_key_received,
    input  logic [7:0] ps2_last_key_received,
    output logic [7:0] ascii_character_out,
    output logic       key_just_pressed
);

    logic release_now;
    logic release_q;
    logic start_q;

    assign release_now = (ps2_last_key_received == BREAK_CODE);

    // The break prefix must be seen on two consecutive edges to count as a release.
    always_ff @(posedge clock) begin
        if (reset) begin
            release_q <= 1'b0;
            start_q   <= 1'b0;
        end else begin
            release_q <= release_now;
            start_q   <= release_q & release_now;
        end
    end

    ps2_delay_timer #(
        .DELAY_CYCLES(DELAY_CYCLES)
    ) u_timer (
        .clock (clock),
        .reset (reset),
        .start (start_q),
        .finish(key_just_pressed)
    );

    // Set-2 make code to lowercase ASCII; anything unmapped reads as NUL.
    always_comb begin
        ascii_character_out = ASCII_NUL;
        case (ps2_key_received)
            SC_A:     ascii_character_out = 8'h61;
            SC_B:     ascii_character_out = 8'h62;
            SC_C:     ascii_character_out = 8'h63;
            SC_D:     ascii_character_out = 8'h64;
            SC_E:     ascii_character_out = 8'h65;
            SC_F:     ascii_character_out = 8'h66;
            SC_G:     ascii_character_out = 8'h67;
            SC_H:     ascii_character_out = 8'h68;
            SC_I:     ascii_character_out = 8'h69;
            SC_J:     ascii_character_out = 8'h6A;
            SC_K:     ascii_character_out = 8'h6B;
            SC_L:     ascii_character_out = 8'h6C;
            SC_M:     ascii_character_out = 8'h6D;
            SC_N:     ascii_character_out = 8'h6E;
            SC_O:     ascii_character_out = 8'h6F;
            SC_P:     ascii_character_out = 8'h70;
            SC_Q:     ascii_character_out = 8'h71;
            SC_R:     ascii_character_out = 8'h72;
            SC_S:     ascii_character_out = 8'h73;
            SC_T:     ascii_character_out = 8'h74;
            SC_U:     ascii_character_out = 8'h75;
            SC_V:     ascii_character_out = 8'h76;
            SC_W:     ascii_character_out = 8'h77;
            SC_X:     ascii_character_out = 8'h78;
            SC_Y:     ascii_character_out = 8'h79;
            SC_Z:     ascii_character_out = 8'h7A;
            SC_0:     ascii_character_out = 8'h30;
            SC_1:     ascii_character_out = 8'h31;
            SC_2:     ascii_character_out = 8'h32;
            SC_3:     ascii_character_out = 8'h33;
            SC_4:     ascii_character_out = 8'h34;
            SC_5:     ascii_character_out = 8'h35;
            SC_6:     ascii_character_out = 8'h36;
            SC_7:     ascii_character_out = 8'h37;
            SC_8:     ascii_character_out = 8'h38;
            SC_9:     ascii_character_out = 8'h39;
            SC_SPACE: ascii_character_out = ASCII_SP;
            SC_ENTER: ascii_character_out = ASCII_CR;
            SC_BKSP:  ascii_character_out = ASCII_BS;
            SC_ESC:   ascii_character_out = ASCII_ESC;
            default:  ascii_character_out = ASCII_NUL;
        endcase
    end

endmodule

// File: tb/tb_ps2_keypress_decoder.sv
// tb/tb_ps2_keypress_decoder.sv - self-checking bench for ps2_keypress_decoder
module tb_ps2_keypress_decoder;

    localparam int DELAY = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] ps2_key_received = 8'h00;
    logic [7:0] ps2_last_key_received = 8'h00;
    logic [7:0] ascii_character_out;
    logic       key_just_pressed;

    int total = 0;
    int bad   = 0;

    ps2_keypress_decoder #(
        .DELAY_CYCLES(DELAY)
    ) dut (
        .clock                (clock),
        .reset                (reset),
        .ps2_key_received     (ps2_key_received),
        .ps2_last_key_received(ps2_last_key_received),
        .ascii_character_out  (ascii_character_out),
        .key_just_pressed     (key_just_pressed)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // Behavioural model: a release level is "F0 on this edge and the last one";
    // its rise, one edge later, books a strobe DELAY edges out unless one is pending.
    int   edge_n = 0;
    logic m_prev_rel = 1'b0;
    logic m_prev_lvl = 1'b0;
    logic m_trig = 1'b0;
    logic m_busy = 1'b0;
    int   m_strobe_at = 0;
    logic exp_strobe = 1'b0;

    always @(posedge clock) begin : model
        logic rel;
        logic lvl;
        logic fire;
        int   this_edge;
        this_edge = edge_n + 1;
        edge_n <= this_edge;
        if (reset) begin
            m_prev_rel <= 1'b0;
            m_prev_lvl <= 1'b0;
            m_trig     <= 1'b0;
            m_busy     <= 1'b0;
            exp_strobe <= 1'b0;
        end else begin
            rel  = (ps2_last_key_received == 8'hF0);
            lvl  = rel & m_prev_rel;
            fire = m_busy && (this_edge == m_strobe_at);
            exp_strobe <= fire;
            if (m_trig && !m_busy) begin
                m_busy      <= 1'b1;
                m_strobe_at <= this_edge + DELAY;
            end else if (fire) begin
                m_busy <= 1'b0;
            end
            m_prev_rel <= rel;
            m_prev_lvl <= lvl;
            m_trig     <= lvl & ~m_prev_lvl;
        end
    end

    // Compare on the falling edge and log where the DUT actually strobed.
    int dut_strobes = 0;
    int dut_last_edge = -1;

    always @(negedge clock) begin
        check("key_just_pressed", 32'(key_just_pressed), 32'(exp_strobe));
        if (key_just_pressed === 1'b1) begin
            dut_strobes++;
            dut_last_edge = edge_n;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    logic [7:0] exp_map [256];
    logic [7:0] letter_sc [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                   8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                   8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] digit_sc [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

    initial begin
        int e0;
        int base;

        // Reset held with F0 present, then released with 00.
        reset = 1'b1;
        ps2_last_key_received = 8'hF0;
        tick(3);
        reset = 1'b0;
        ps2_last_key_received = 8'h00;
        tick(2);
        check("reset_no_strobe", 32'(dut_strobes), 32'd0);

        // Nominal: F0 held, strobe after edge E0+6, and only once.
        e0 = edge_n + 1;
        ps2_last_key_received = 8'hF0;
        tick(10);
        check("nominal_count", 32'(dut_strobes), 32'd1);
        check("nominal_edge", 32'(dut_last_edge), 32'(e0 + 6));
        tick(50);
        check("held_single", 32'(dut_strobes), 32'd1);

        // Glitch: F0 for one edge only.
        ps2_last_key_received = 8'h00;
        tick(5);
        base = dut_strobes;
        ps2_last_key_received = 8'hF0;
        tick(1);
        ps2_last_key_received = 8'h00;
        tick(20);
        check("glitch_none", 32'(dut_strobes - base), 32'd0);

        // Two separated releases give two strobes.
        for (int i = 0; i < 2; i++) begin
            ps2_last_key_received = 8'hF0;
            tick(10);
            ps2_last_key_received = 8'h00;
            tick(10);
        end
        check("two_strobes", 32'(dut_strobes - base), 32'd2);

        // Retrigger while running is ignored.
        base = dut_strobes;
        e0 = edge_n + 1;
        ps2_last_key_received = 8'hF0;
        tick(2);
        ps2_last_key_received = 8'h00;
        tick(1);
        ps2_last_key_received = 8'hF0;
        tick(2);
        ps2_last_key_received = 8'h00;
        tick(15);
        check("retrig_count", 32'(dut_strobes - base), 32'd1);
        check("retrig_edge", 32'(dut_last_edge), 32'(e0 + 6));

        // Reset at E3 aborts the count; the next release behaves normally.
        base = dut_strobes;
        ps2_last_key_received = 8'hF0;
        tick(3);
        reset = 1'b1;
        ps2_last_key_received = 8'h00;
        tick(1);
        reset = 1'b0;
        tick(12);
        check("abort_none", 32'(dut_strobes - base), 32'd0);
        e0 = edge_n + 1;
        ps2_last_key_received = 8'hF0;
        tick(10);
        ps2_last_key_received = 8'h00;
        check("after_abort_count", 32'(dut_strobes - base), 32'd1);
        check("after_abort_edge", 32'(dut_last_edge), 32'(e0 + 6));
        tick(3);

        // ASCII map: hand-picked literals, then a full sweep against the table.
        for (int i = 0; i < 256; i++) exp_map[i] = 8'h00;
        for (int i = 0; i < 26; i++) exp_map[letter_sc[i]] = 8'(8'h61 + i);
        for (int i = 0; i < 10; i++) exp_map[digit_sc[i]] = 8'(8'h30 + i);
        exp_map[8'h29] = 8'h20;
        exp_map[8'h5A] = 8'h0D;
        exp_map[8'h66] = 8'h08;
        exp_map[8'h76] = 8'h1B;

        ps2_key_received = 8'h1C; #1 check("ascii_1C", 32'(ascii_character_out), 32'h61);
        ps2_key_received = 8'h45; #1 check("ascii_45", 32'(ascii_character_out), 32'h30);
        ps2_key_received = 8'h29; #1 check("ascii_29", 32'(ascii_character_out), 32'h20);
        ps2_key_received = 8'h5A; #1 check("ascii_5A", 32'(ascii_character_out), 32'h0D);
        ps2_key_received = 8'h66; #1 check("ascii_66", 32'(ascii_character_out), 32'h08);
        ps2_key_received = 8'h76; #1 check("ascii_76", 32'(ascii_character_out), 32'h1B);
        ps2_key_received = 8'hF0; #1 check("ascii_F0", 32'(ascii_character_out), 32'h00);
        ps2_key_received = 8'h7F; #1 check("ascii_7F", 32'(ascii_character_out), 32'h00);
        ps2_key_received = 8'h1A; #1 check("ascii_1A", 32'(ascii_character_out), 32'h7A);

        for (int i = 0; i < 256; i++) begin
            ps2_key_received = 8'(i);
            #1;
            check($sformatf("ascii_sweep_%02h", i), 32'(ascii_character_out), 32'(exp_map[i]));
        end

        tick(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
